vga_frame_fetch: RTL and testbench

Pixel prefetch stage directly upstream of the VGA timing controller. Fetches each frame's RGB565 pixels from external memory in fixed-length read bursts, buffers them in an internal FIFO, and returns one pixel per `data_req` with one-cycle latency on `dout`. `dout` drives the controller's `din`. The block restarts at the frame base address on every new frame (`frame_sync`) and flags underflow.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_frame_fetch_if.sv | 14 +
 rtl/vga_frame_fetch_chk.sv | 33 +++
 rtl/vga_pixel_fifo.sv | 79 +++++++
 rtl/vga_frame_fetch.sv | 156 +++++++++++++++
 tb/tb_vga_frame_fetch.sv | 210 +++++++++++++++++++++
 6 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel fetch path.
// The frame constants are the same ones the timing controller uses.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    CHECK = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } fetch_state_e;

  // RGB565 pixel layout: {B5, G6, R5}
  localparam int RGB_R_LSB = 0;
  localparam int RGB_R_W   = 5;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_G_W   = 6;
  localparam int RGB_B_LSB = 11;
  localparam int RGB_B_W   = 5;

  localparam int H_ACTIVE       = 1024;
  localparam int V_ACTIVE       = 768;
  localparam int FRAME_PIXELS   = H_ACTIVE * V_ACTIVE;
  localparam int DEF_BURST_LEN  = 256;
  localparam int DEF_FIFO_DEPTH = 512;

  function automatic logic [15:0] rgb565_pack(input logic [4:0] r,
                                              input logic [5:0] g,
                                              input logic [4:0] b);
    return {b, g, r};
  endfunction

endpackage

// File: rtl/vga_frame_fetch_if.sv
// Burst-read memory port used by the frame fetcher.
// One request is outstanding at a time; beats return on mem_rvalid.
interface vga_frame_fetch_if #(parameter int ADDR_W = 24);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [15:0]       mem_rdata;

  modport master (output mem_req, mem_addr,
                  input  mem_ack, mem_rvalid, mem_rdata);
  modport slave  (input  mem_req, mem_addr,
                  output mem_ack, mem_rvalid, mem_rdata);
endinterface

// File: rtl/vga_frame_fetch_chk.sv
// Simulation checkers for the frame fetcher and its pixel FIFO.
// They only observe; nothing here drives design state.
module vga_pixel_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic full
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full));
endmodule

module vga_frame_fetch_chk #(parameter int ADDR_W = 24) (
  input logic              clk,
  input logic              rst_n,
  input logic              mem_req,
  input logic              mem_ack,
  input logic [ADDR_W-1:0] mem_addr,
  input logic              frame_start,
  input logic              data_lock,
  input logic              data_req,
  input logic              fifo_empty
);
  // A pending request may only be withdrawn by a new frame
  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req && !mem_ack && !frame_start) |=> (mem_req && $stable(mem_addr)));

  a_req_drop_after_ack: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req && mem_ack) |=> !mem_req);

  c_underflow_in_active_line: cover property (@(posedge clk) disable iff (!rst_n)
    data_lock && data_req && fifo_empty);
endmodule

// File: rtl/vga_pixel_fifo.sv
// Single-clock pixel FIFO with flush, registered read data and level.
// A pop while empty returns zero; flush overrides push and pop.
module vga_pixel_fifo #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [15:0]              wdata,
  input  logic                     pop,
  output logic [15:0]              rdata,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [15:0]   rdata_r;
  logic          empty_s, full_s, do_push_s, do_pop_s;

  assign empty_s   = (level_r == {LW{1'b0}});
  assign full_s    = (level_r == LW'(DEPTH));
  assign do_push_s = push && !flush;
  assign do_pop_s  = pop && !flush && !empty_s;

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Registered read data: head on pop, zero on empty pop, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 16'h0000;
    end else if (flush) begin
      rdata_r <= rdata_r;
    end else if (pop) begin
      rdata_r <= empty_s ? 16'h0000 : mem_r[rd_ptr_r];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;
  assign level = level_r;

  vga_pixel_fifo_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push_s),
    .full  (full_s)
  );
endmodule

// File: rtl/vga_frame_fetch.sv
// Pixel prefetch ahead of the VGA timing controller: bursts frame pixels
// from memory into a FIFO and hands one out per data_req, one cycle later.
module vga_frame_fetch import vga_pkg::*; #(
  parameter int                DISPLAY_PIXELS = FRAME_PIXELS,
  parameter int                FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int                BURST_LEN      = DEF_BURST_LEN,
  parameter int                ADDR_W         = 24,
  parameter logic [ADDR_W-1:0] FRAME_BASE     = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_sync,
  input  logic                        data_lock,
  input  logic                        data_req,
  output logic [15:0]                 dout,
  vga_frame_fetch_if.master           mem,
  output logic                        underflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(DISPLAY_PIXELS + 1);
  localparam int BW = $clog2(BURST_LEN);

  fetch_state_e      state_r, state_s;
  logic              frame_sync_d_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CW-1:0]     req_cnt_r;
  logic [BW-1:0]     beat_cnt_r;
  logic              mem_req_r;
  logic              underflow_r;
  logic              frame_start_s, beat_last_s, space_ok_s, push_s, flush_s;
  logic [15:0]       dout_s;
  logic [LW-1:0]     fifo_level_s;

  assign frame_start_s = frame_sync && !frame_sync_d_r;
  assign beat_last_s   = mem.mem_rvalid && (beat_cnt_r == BW'(BURST_LEN - 1));
  assign space_ok_s    = (LW'(FIFO_DEPTH) - fifo_level_s) >= LW'(BURST_LEN);
  assign flush_s       = (state_r == FLUSH);
  // A beat arriving with a new frame start belongs to the old frame
  assign push_s        = (state_r == WAIT) && mem.mem_rvalid && !frame_start_s;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start_s) state_s = FLUSH;
        else               state_s = IDLE;
      end
      FLUSH: state_s = CHECK;
      CHECK: begin
        if (frame_start_s)                           state_s = FLUSH;
        else if (req_cnt_r == CW'(DISPLAY_PIXELS))   state_s = DONE;
        else if (space_ok_s)                         state_s = ISSUE;
        else                                         state_s = CHECK;
      end
      ISSUE: begin
        if (mem.mem_ack)        state_s = frame_start_s ? DRAIN : WAIT;
        else if (frame_start_s) state_s = FLUSH;
        else                    state_s = ISSUE;
      end
      WAIT: begin
        // A frame start on the final beat has nothing left to drain
        if (beat_last_s)        state_s = frame_start_s ? FLUSH : CHECK;
        else if (frame_start_s) state_s = DRAIN;
        else                    state_s = WAIT;
      end
      DRAIN: begin
        if (beat_last_s) state_s = FLUSH;
        else             state_s = DRAIN;
      end
      DONE: begin
        if (frame_start_s) state_s = FLUSH;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, frame_sync history, request strobe and burst counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      frame_sync_d_r <= 1'b0;
      mem_req_r      <= 1'b0;
      addr_r         <= {ADDR_W{1'b0}};
      req_cnt_r      <= {CW{1'b0}};
      beat_cnt_r     <= {BW{1'b0}};
    end else begin
      state_r        <= state_s;
      frame_sync_d_r <= frame_sync;
      mem_req_r      <= (state_s == ISSUE);
      case (state_r)
        FLUSH: begin
          addr_r    <= FRAME_BASE;
          req_cnt_r <= {CW{1'b0}};
        end
        ISSUE: begin
          if (mem.mem_ack) begin
            addr_r     <= addr_r + ADDR_W'(BURST_LEN);
            req_cnt_r  <= req_cnt_r + CW'(BURST_LEN);
            beat_cnt_r <= {BW{1'b0}};
          end
        end
        WAIT, DRAIN: begin
          if (mem.mem_rvalid) beat_cnt_r <= beat_cnt_r + 1'b1;
        end
        default: begin
          beat_cnt_r <= beat_cnt_r;
        end
      endcase
    end
  end

  // Sticky underflow, cleared only by a frame flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_r <= 1'b0;
    end else if (flush_s) begin
      underflow_r <= 1'b0;
    end else if (data_req && (fifo_level_s == {LW{1'b0}})) begin
      underflow_r <= 1'b1;
    end else begin
      underflow_r <= underflow_r;
    end
  end

  vga_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_s),
    .push  (push_s),
    .wdata (mem.mem_rdata),
    .pop   (data_req),
    .rdata (dout_s),
    .level (fifo_level_s)
  );

  assign mem.mem_req  = mem_req_r;
  assign mem.mem_addr = addr_r;
  assign dout         = dout_s;
  assign underflow    = underflow_r;
  assign fifo_level   = fifo_level_s;

  vga_frame_fetch_chk #(.ADDR_W(ADDR_W)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req_r),
    .mem_ack     (mem.mem_ack),
    .mem_addr    (addr_r),
    .frame_start (frame_start_s),
    .data_lock   (data_lock),
    .data_req    (data_req),
    .fifo_empty  (fifo_level_s == {LW{1'b0}})
  );
endmodule

// File: tb/tb_vga_frame_fetch.sv
// Directed bench for vga_frame_fetch with a 1024-pixel frame and 256-word bursts.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_vga_frame_fetch;
  localparam int DP = 1024;
  localparam int FD = 512;
  localparam int BL = 256;
  localparam int AW = 24;

  logic        clk = 1'b0;
  logic        rst_n, frame_sync, data_lock, data_req;
  logic [15:0] dout;
  logic        underflow;
  logic [9:0]  fifo_level;
  int          vectors = 0;
  int          miscompares = 0;

  vga_frame_fetch_if #(.ADDR_W(AW)) mem_bus ();

  vga_frame_fetch #(
    .DISPLAY_PIXELS (DP),
    .FIFO_DEPTH     (FD),
    .BURST_LEN      (BL),
    .ADDR_W         (AW),
    .FRAME_BASE     (24'h000000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_sync (frame_sync),
    .data_lock  (data_lock),
    .data_req   (data_req),
    .dout       (dout),
    .mem        (mem_bus.master),
    .underflow  (underflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_sync = 1'b0; data_lock = 1'b0; data_req = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 16'h0000;
    step(); step();
    vectors++; if (dout !== 16'h0000) begin miscompares++; $display("FAIL reset_dout: got %h want 0000", dout); end
    vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", mem_bus.mem_req); end
    vectors++; if (mem_bus.mem_addr !== 24'h000000) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 000000", mem_bus.mem_addr); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    vectors++; if (fifo_level !== 10'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    rst_n = 1'b1;
    step(); step();
    vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL idle_no_req: got %b want 0", mem_bus.mem_req); end
  endtask

  task automatic test_first_request();
    frame_sync = 1'b1;
    step();  // E0 -> FLUSH
    vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL req_after_e0: got %b want 0", mem_bus.mem_req); end
    step();  // E1 -> CHECK
    vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL req_after_e1: got %b want 0", mem_bus.mem_req); end
    step();  // E2 -> ISSUE
    frame_sync = 1'b0;
    vectors++; if (mem_bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL req_after_e2: got %b want 1", mem_bus.mem_req); end
    vectors++; if (mem_bus.mem_addr !== 24'h000000) begin miscompares++; $display("FAIL first_addr: got %h want 000000", mem_bus.mem_addr); end
    mem_bus.mem_ack = 1'b1; step(); mem_bus.mem_ack = 1'b0;
    vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL req_low_after_ack: got %b want 0", mem_bus.mem_req); end
    for (int i = 0; i < BL; i++) begin
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 16'(i); step();
    end
    mem_bus.mem_rvalid = 1'b0;
    vectors++; if (fifo_level !== 10'd256) begin miscompares++; $display("FAIL level_burst0: got %0d want 256", fifo_level); end
    step();
    vectors++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 24'd256) begin
      miscompares++; $display("FAIL second_req: got req %b addr %h want req 1 addr 000100", mem_bus.mem_req, mem_bus.mem_addr); end
    mem_bus.mem_ack = 1'b1; step(); mem_bus.mem_ack = 1'b0;
    for (int i = 0; i < BL; i++) begin
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 16'(i); step();
    end
    mem_bus.mem_rvalid = 1'b0;
    vectors++; if (fifo_level !== 10'd512) begin miscompares++; $display("FAIL level_full: got %0d want 512", fifo_level); end
    step(); step(); step();
    vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL no_req_when_full: got %b want 0", mem_bus.mem_req); end
  endtask

  task automatic test_stream();
    data_lock = 1'b1;
    for (int i = 0; i < BL; i++) begin
      data_req = 1'b1; step();
      vectors++; if (dout !== 16'(i)) begin miscompares++; $display("FAIL stream_pix%0d: got %h want %h", i, dout, 16'(i)); end
    end
    data_req = 1'b0;
    vectors++; if (fifo_level !== 10'd256) begin miscompares++; $display("FAIL level_after_stream: got %0d want 256", fifo_level); end
    step();
    vectors++; if (dout !== 16'h00ff) begin miscompares++; $display("FAIL dout_hold: got %h want 00ff", dout); end
    vectors++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 24'd512) begin
      miscompares++; $display("FAIL third_req: got req %b addr %h want req 1 addr 000200", mem_bus.mem_req, mem_bus.mem_addr); end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < BL; i++) begin
      data_req = 1'b1; step();
      vectors++; if (dout !== 16'(i)) begin miscompares++; $display("FAIL drain_pix%0d: got %h want %h", i, dout, 16'(i)); end
    end
    data_req = 1'b1; step(); data_req = 1'b0;
    vectors++; if (dout !== 16'h0000) begin miscompares++; $display("FAIL empty_pop_dout: got %h want 0000", dout); end
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_set: got %b want 1", underflow); end
    step();
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky: got %b want 1", underflow); end
    frame_sync = 1'b1;
    step();  // ISSUE without ack -> FLUSH
    vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL req_dropped: got %b want 0", mem_bus.mem_req); end
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_in_flush: got %b want 1", underflow); end
    step();  // -> CHECK
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL underflow_cleared: got %b want 0", underflow); end
    step();  // -> ISSUE
    frame_sync = 1'b0;
    vectors++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 24'd0) begin
      miscompares++; $display("FAIL restart_req: got req %b addr %h want req 1 addr 000000", mem_bus.mem_req, mem_bus.mem_addr); end
  endtask

  task automatic test_mid_burst();
    mem_bus.mem_ack = 1'b1; step(); mem_bus.mem_ack = 1'b0;
    for (int i = 0; i < 100; i++) begin
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 16'hA000 + 16'(i); step();
    end
    mem_bus.mem_rvalid = 1'b0;
    vectors++; if (fifo_level !== 10'd100) begin miscompares++; $display("FAIL level_beat100: got %0d want 100", fifo_level); end
    frame_sync = 1'b1;
    step();  // WAIT -> DRAIN
    for (int i = 0; i < BL - 100; i++) begin
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 16'hB000 + 16'(i); step();
    end
    mem_bus.mem_rvalid = 1'b0; frame_sync = 1'b0;
    vectors++; if (fifo_level !== 10'd100 || mem_bus.mem_req !== 1'b0) begin
      miscompares++; $display("FAIL drain_discard: got level %0d req %b want level 100 req 0", fifo_level, mem_bus.mem_req); end
    step();  // FLUSH -> CHECK
    vectors++; if (fifo_level !== 10'd0) begin miscompares++; $display("FAIL level_after_flush: got %0d want 0", fifo_level); end
    step();  // -> ISSUE
    vectors++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 24'd0) begin
      miscompares++; $display("FAIL addr_after_drain: got req %b addr %h want req 1 addr 000000", mem_bus.mem_req, mem_bus.mem_addr); end
  endtask

  task automatic test_ack_frame_start();
    mem_bus.mem_ack = 1'b1; frame_sync = 1'b1;
    step();  // ISSUE + ack + frame start -> DRAIN
    mem_bus.mem_ack = 1'b0; frame_sync = 1'b0;
    vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL req_low_in_drain: got %b want 0", mem_bus.mem_req); end
    for (int i = 0; i < BL - 1; i++) begin
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 16'hC000 + 16'(i); step();
    end
    mem_bus.mem_rvalid = 1'b0;
    step(); step();
    vectors++; if (mem_bus.mem_req !== 1'b0 || fifo_level !== 10'd0) begin
      miscompares++; $display("FAIL drain_255_still_draining: got req %b level %0d want req 0 level 0", mem_bus.mem_req, fifo_level); end
    mem_bus.mem_rvalid = 1'b1; step(); mem_bus.mem_rvalid = 1'b0;  // beat 256 -> FLUSH
    step();  // -> CHECK
    vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL req_in_check: got %b want 0", mem_bus.mem_req); end
    step();  // -> ISSUE
    vectors++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 24'd0) begin
      miscompares++; $display("FAIL req_after_256_drain: got req %b addr %h want req 1 addr 000000", mem_bus.mem_req, mem_bus.mem_addr); end
  endtask

  task automatic test_full_frame();
    int n;
    for (int k = 0; k < DP / BL; k++) begin
      n = 0;
      while (mem_bus.mem_req !== 1'b1 && n < 50) begin step(); n++; end
      vectors++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 24'(k * BL)) begin
        miscompares++; $display("FAIL frame_req%0d: got req %b addr %h want req 1 addr %h", k, mem_bus.mem_req, mem_bus.mem_addr, 24'(k * BL)); end
      mem_bus.mem_ack = 1'b1; step(); mem_bus.mem_ack = 1'b0;
      for (int i = 0; i < BL; i++) begin
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 16'(k * BL + i); step();
      end
      mem_bus.mem_rvalid = 1'b0;
      for (int i = 0; i < BL; i++) begin
        data_req = 1'b1; step();
        vectors++; if (dout !== 16'(k * BL + i)) begin
          miscompares++; $display("FAIL frame_pix%0d: got %h want %h", k * BL + i, dout, 16'(k * BL + i)); end
      end
      data_req = 1'b0;
    end
    for (int t = 0; t < 20; t++) begin
      step();
      vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL done_no_req_t%0d: got %b want 0", t, mem_bus.mem_req); end
    end
    vectors++; if (fifo_level !== 10'd0 || underflow !== 1'b0) begin
      miscompares++; $display("FAIL frame_end: got level %0d underflow %b want 0 0", fifo_level, underflow); end
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_stream();
    test_underflow();
    test_mid_burst();
    test_ack_frame_start();
    test_full_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
